// File: rtl/alu_issue.sv
// Decode-to-execute issue stage for the integer ALU: operand forwarding, imm/PC select, elastic buffer.
// Optional 2-entry skid buffer enabled by defining ALU_ISSUE_SKID_EN.
module alu_issue #(
  parameter int XLEN    = 32,
  parameter int RF_ADDR = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [RF_ADDR-1:0] in_rs1,
  input  logic [RF_ADDR-1:0] in_rs2,
  input  logic [RF_ADDR-1:0] in_rd,
  input  logic [XLEN-1:0]    in_rs1_val,
  input  logic [XLEN-1:0]    in_rs2_val,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               in_op,
  input  logic               in_op_imm,
  input  logic               in_lui,
  input  logic               in_auipc,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_a,
  output logic [XLEN-1:0]    out_b,
  output logic               out_op,
  output logic               out_op_imm,
  output logic [2:0]         out_funct3,
  output logic [6:0]         out_funct7,
  output logic [RF_ADDR-1:0] out_rd,
  input  logic [XLEN-1:0]    ex_t,
  input  logic               wb_wen,
  input  logic [RF_ADDR-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic               op;
    logic               op_imm;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [RF_ADDR-1:0] rd;
  } entry_t;

  state_t          state_r;
  entry_t          out_r;
  entry_t          new_s;
  logic            out_valid_r;
  logic            xfer_s;
  logic            u_type_s;
  logic            legal_s;
  logic            shift_s;
  logic [XLEN-1:0] rs1_fwd_s;
  logic [XLEN-1:0] rs2_fwd_s;
  logic [XLEN-1:0] b_raw_s;

`ifdef ALU_ISSUE_SKID_EN
  entry_t skid_r;
  logic   in_ready_r;
  assign in_ready = in_ready_r;
`else
  assign in_ready = ~out_valid_r | out_ready;
`endif

  assign xfer_s     = in_valid & in_ready;
  assign out_valid  = out_valid_r;
  assign out_a      = out_r.a;
  assign out_b      = out_r.b;
  assign out_op     = out_r.op;
  assign out_op_imm = out_r.op_imm;
  assign out_funct3 = out_r.funct3;
  assign out_funct7 = out_r.funct7;
  assign out_rd     = out_r.rd;

  // Source forwarding; rsX!=0 already implies the OUT producer has a nonzero rd, EX beats WB.
  always_comb begin
    if (in_rs1 == {RF_ADDR{1'b0}})                    rs1_fwd_s = {XLEN{1'b0}};
    else if (out_valid_r && (out_r.rd == in_rs1))     rs1_fwd_s = ex_t;
    else if (wb_wen && (wb_rd == in_rs1))             rs1_fwd_s = wb_data;
    else                                              rs1_fwd_s = in_rs1_val;
    if (in_rs2 == {RF_ADDR{1'b0}})                    rs2_fwd_s = {XLEN{1'b0}};
    else if (out_valid_r && (out_r.rd == in_rs2))     rs2_fwd_s = ex_t;
    else if (wb_wen && (wb_rd == in_rs2))             rs2_fwd_s = wb_data;
    else                                              rs2_fwd_s = in_rs2_val;
  end

  // Build the entry captured on a transfer; U-types become an add of a and imm.
  always_comb begin
    u_type_s = in_lui | in_auipc;
    legal_s  = ({in_op, in_op_imm, in_lui, in_auipc} == 4'b1000) ||
               ({in_op, in_op_imm, in_lui, in_auipc} == 4'b0100) ||
               ({in_op, in_op_imm, in_lui, in_auipc} == 4'b0010) ||
               ({in_op, in_op_imm, in_lui, in_auipc} == 4'b0001);
    shift_s  = ~u_type_s & ((in_funct3 == 3'b001) | (in_funct3 == 3'b101));
    b_raw_s  = (in_op_imm | u_type_s) ? in_imm : rs2_fwd_s;
    if (in_auipc)     new_s.a = in_pc;
    else if (in_lui)  new_s.a = {XLEN{1'b0}};
    else              new_s.a = rs1_fwd_s;
    if (shift_s)      new_s.b = {{(XLEN-5){1'b0}}, b_raw_s[4:0]};
    else              new_s.b = b_raw_s;
    if (!legal_s) begin
      new_s.op     = 1'b0;
      new_s.op_imm = 1'b0;
      new_s.funct3 = in_funct3;
      new_s.funct7 = in_funct7;
    end else if (u_type_s) begin
      new_s.op     = 1'b0;
      new_s.op_imm = 1'b1;
      new_s.funct3 = 3'b000;
      new_s.funct7 = 7'b0000000;
    end else begin
      new_s.op     = in_op;
      new_s.op_imm = in_op_imm;
      new_s.funct3 = in_funct3;
      new_s.funct7 = in_funct7;
    end
    new_s.rd = in_rd;
  end

  // Occupancy FSM; flush and reset empty both entries without advancing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      out_r       <= {$bits(entry_t){1'b0}};
`ifdef ALU_ISSUE_SKID_EN
      skid_r      <= {$bits(entry_t){1'b0}};
      in_ready_r  <= 1'b1;
`endif
    end else if (flush) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
`ifdef ALU_ISSUE_SKID_EN
      in_ready_r  <= 1'b1;
`endif
    end else begin
      case (state_r)
        EMPTY: begin
          if (xfer_s) begin
            out_r       <= new_s;
            out_valid_r <= 1'b1;
            state_r     <= ONE;
          end
        end
        ONE: begin
          if (xfer_s && out_ready) begin
            out_r <= new_s;
`ifdef ALU_ISSUE_SKID_EN
          end else if (xfer_s) begin
            skid_r     <= new_s;
            in_ready_r <= 1'b0;
            state_r    <= FULL;
`endif
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= EMPTY;
          end
        end
`ifdef ALU_ISSUE_SKID_EN
        FULL: begin
          if (out_ready) begin
            out_r      <= skid_r;
            in_ready_r <= 1'b1;
            state_r    <= ONE;
          end
        end
`endif
        default: begin
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
`ifdef ALU_ISSUE_SKID_EN
          in_ready_r  <= 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed literal cases plus randomized traffic against a queue model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_op, in_op_imm, in_lui, in_auipc;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic        out_op, out_op_imm;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic [31:0] ex_t;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;
  bit live  = 1'b0;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_op(in_op), .in_op_imm(in_op_imm), .in_lui(in_lui), .in_auipc(in_auipc),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_op(out_op), .out_op_imm(out_op_imm), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rd(out_rd),
    .ex_t(ex_t), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        op_imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    bit          illegal;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
`ifdef ALU_ISSUE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || (out_ready == 1'b1);
`endif
  endfunction

  // Register value an instruction should see: x0 is zero, then the instr in OUT, then WB, then RF.
  function automatic logic [31:0] src(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (q.size() > 0 && q[0].rd == rs) return ex_t;
    if (wb_wen && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  function automatic exp_t capture();
    exp_t e;
    int   n;
    bit   u;
    n = int'(in_op) + int'(in_op_imm) + int'(in_lui) + int'(in_auipc);
    u = in_lui || in_auipc;
    e.illegal = (n != 1);
    e.a  = in_auipc ? in_pc : (in_lui ? 32'd0 : src(in_rs1, in_rs1_val));
    e.b  = (in_op_imm || u) ? in_imm : src(in_rs2, in_rs2_val);
    if (!u && (in_funct3 == 3'd1 || in_funct3 == 3'd5)) e.b = e.b & 32'h1f;
    e.op = in_op; e.op_imm = in_op_imm; e.f3 = in_funct3; e.f7 = in_funct7;
    if (u) begin e.op = 1'b0; e.op_imm = 1'b1; e.f3 = 3'd0; e.f7 = 7'd0; end
    if (e.illegal) begin e.op = 1'b0; e.op_imm = 1'b0; end
    e.rd = in_rd;
    return e;
  endfunction

  // Reference model: a FIFO of what the ALU must see, head = OUT.
  always @(posedge clk) begin
    exp_t e;
    bit   xfer;
    if (!rst_n) begin
      q.delete();
      live = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      xfer = in_valid && model_ready();
      if (xfer) e = capture();
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (xfer) q.push_back(e);
    end
  end

  // Cycle compare on the falling edge.
  always @(negedge clk) begin
    if (live) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
      if (q.size() > 0 && out_valid) begin
        check("out_op", {31'd0, out_op}, {31'd0, q[0].op});
        check("out_op_imm", {31'd0, out_op_imm}, {31'd0, q[0].op_imm});
        check("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
        if (!q[0].illegal) begin
          check("out_a", out_a, q[0].a);
          check("out_b", out_b, q[0].b);
          check("out_funct3", {29'd0, out_funct3}, {29'd0, q[0].f3});
          check("out_funct7", {25'd0, out_funct7}, {25'd0, q[0].f7});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; wb_wen = 1'b0;
  endtask

  // kind: 0 OP, 1 OP-IMM, 2 LUI, 3 AUIPC, 4 illegal (OP+LUI)
  task automatic drive(input int kind, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] pc);
    in_valid = 1'b1;
    in_op = (kind == 0) || (kind == 4); in_op_imm = (kind == 1);
    in_lui = (kind == 2) || (kind == 4); in_auipc = (kind == 3);
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rs1_val = v1; in_rs2_val = v2;
    in_imm = imm; in_funct3 = f3; in_funct7 = f7; in_pc = pc;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; ex_t = 32'd0;
    wb_wen = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    drive(1, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd7, 3'd0, 7'd0, 32'd0);

    // Reset with in_valid held high: nothing accepted.
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_rd", {27'd0, out_rd}, 32'd0);
    rst_n = 1'b1; idle(); tick();
    check("rst_nothing_kept", {31'd0, out_valid}, 32'd0);

    // ADDI x1,x0,5 then ADD x2,x1,x1 with EX forwarding.
    drive(1, 5'd0, 5'd0, 5'd1, 32'hDEAD, 32'd0, 32'd5, 3'd0, 7'd0, 32'h10); tick();
    check("addi_a", out_a, 32'd0);
    check("addi_b", out_b, 32'd5);
    drive(0, 5'd1, 5'd1, 5'd2, 32'h111, 32'h222, 32'd0, 3'd0, 7'd0, 32'h14); ex_t = 32'd5; tick();
    check("add_fwd_a", out_a, 32'd5);
    check("add_fwd_b", out_b, 32'd5);
    check("add_op", {31'd0, out_op}, 32'd1);

    // EX beats WB, WB alone, x0 never forwarded.
    drive(0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'd0, 3'd0, 7'd0, 32'h18); tick();
    drive(1, 5'd3, 5'd0, 5'd4, 32'h77, 32'd0, 32'd0, 3'd0, 7'd0, 32'h1C);
    ex_t = 32'h55; wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 32'hAA; tick();
    check("ex_over_wb", out_a, 32'h55);
    drive(1, 5'd5, 5'd0, 5'd6, 32'h77, 32'd0, 32'd0, 3'd0, 7'd0, 32'h20);
    wb_rd = 5'd5; wb_data = 32'hBB; tick();
    check("wb_fwd", out_a, 32'hBB);
    drive(1, 5'd0, 5'd0, 5'd7, 32'h99, 32'd0, 32'd0, 3'd0, 7'd0, 32'h24);
    wb_rd = 5'd0; wb_data = 32'hAA; tick();
    check("x0_zero", out_a, 32'd0);

    // SRAI shamt masking and AUIPC operand select.
    wb_wen = 1'b0;
    drive(1, 5'd8, 5'd0, 5'd8, 32'h80000000, 32'd0, 32'h405, 3'd5, 7'h20, 32'h28); tick();
    check("srai_b", out_b, 32'd5);
    check("srai_f7", {25'd0, out_funct7}, 32'h20);
    check("srai_a", out_a, 32'h80000000);
    drive(3, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h1000, 3'd0, 7'd0, 32'h100); tick();
    check("auipc_a", out_a, 32'h100);
    check("auipc_b", out_b, 32'h1000);
    check("auipc_f3", {29'd0, out_funct3}, 32'd0);
    check("auipc_op_imm", {31'd0, out_op_imm}, 32'd1);

    // Back-pressure: three pushes while stalled, then release.
    idle(); tick();
    out_ready = 1'b0;
    drive(1, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 32'd10, 3'd0, 7'd0, 32'h200); tick();
    drive(1, 5'd0, 5'd0, 5'd11, 32'd0, 32'd0, 32'd11, 3'd0, 7'd0, 32'h204); tick();
    drive(1, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 32'd12, 3'd0, 7'd0, 32'h208); tick();
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_head", {27'd0, out_rd}, 32'd10);
    idle(); out_ready = 1'b1; tick();
`ifdef ALU_ISSUE_SKID_EN
    check("release_second", {27'd0, out_rd}, 32'd11);
    check("release_second_b", out_b, 32'd11);
    tick();
`endif
    check("release_drained", {31'd0, out_valid}, 32'd0);

    // Flush while held, with a concurrent push that must vanish.
    out_ready = 1'b0;
    drive(1, 5'd0, 5'd0, 5'd13, 32'd0, 32'd0, 32'd13, 3'd0, 7'd0, 32'h300); tick();
    drive(1, 5'd0, 5'd0, 5'd14, 32'd0, 32'd0, 32'd14, 3'd0, 7'd0, 32'h304); tick();
    drive(1, 5'd0, 5'd0, 5'd15, 32'd0, 32'd0, 32'd15, 3'd0, 7'd0, 32'h308);
    flush = 1'b1; out_ready = 1'b1; tick();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    idle(); tick(); tick();
    check("flush_dropped", {31'd0, out_valid}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      k = $urandom_range(0, 40);
      k = (k == 40) ? 4 : (k % 4);
      drive(k, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
            $urandom);
      if (k == 2 || k == 3) in_funct3 = 3'd0;
      in_valid = ($urandom_range(0, 3) != 0);
      ex_t     = $urandom;
      wb_wen   = $urandom_range(0, 1) == 1;
      wb_rd    = 5'($urandom_range(0, 3));
      wb_data  = $urandom;
      tick();
    end
    rst_n = 1'b1; idle(); out_ready = 1'b1;
    tick(); tick(); tick();
    check("final_drain", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
